// File: rtl/cache_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory signals seen by cache_arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches plus memory.
interface cache_arbiter_if;
    logic         i_read;
    logic [15:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I/D cache line fills and write-backs onto one physical memory port.
// Latency: pmem command one cycle after the request is sampled; resp is same-cycle with pmem_resp.
// Backpressure: requests are held off while busy; one IDLE bubble between transactions.
// Optional round-robin tie-break: define CACHE_ARBITER_RR_EN (default build lets D win every tie).
module cache_arbiter (
    input  logic           clk,
    input  logic           reset,
    cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, I_BUSY = 2'd1, D_BUSY = 2'd2} state_t;

    state_t       state;
    state_t       state_nxt;
    logic         op_write;
    logic [15:0]  lat_addr;
    logic [127:0] lat_wdata;
    logic         i_req;
    logic         d_req;
    logic         grant_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARBITER_RR_EN
    // 0 = I granted last, 1 = D granted last; reset to I so D wins the first tie.
    logic last_grant;

    assign grant_d = d_req & (~i_req | ~last_grant);

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b0;
        else if (state == IDLE && (i_req || d_req))
            last_grant <= grant_d;
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)
                    state_nxt = D_BUSY;
                else if (i_req)
                    state_nxt = I_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (bus.pmem_resp)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write wins when the D side asserts read and write together.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_write  <= 1'b0;
            lat_addr  <= 16'h0;
            lat_wdata <= 128'h0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                op_write  <= bus.d_write;
                lat_addr  <= {bus.d_addr[15:4], 4'h0};
                lat_wdata <= bus.d_wdata;
            end else if (i_req) begin
                op_write  <= 1'b0;
                lat_addr  <= {bus.i_addr[15:4], 4'h0};
                lat_wdata <= 128'h0;
            end
        end
    end

    always_comb begin
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = 16'h0;
        bus.pmem_wdata   = 128'h0;
        bus.i_resp       = 1'b0;
        bus.d_resp       = 1'b0;
        if (state == I_BUSY || state == D_BUSY) begin
            bus.pmem_read    = ~op_write;
            bus.pmem_write   = op_write;
            bus.pmem_address = lat_addr;
            bus.pmem_wdata   = lat_wdata;
        end
        // A reset landing on the completing cycle abandons the transaction.
        bus.i_resp = (state == I_BUSY) & bus.pmem_resp & ~reset;
        bus.d_resp = (state == D_BUSY) & bus.pmem_resp & ~reset;
    end

    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, listed as the first two ports below.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_read  input  1  instruction-cache line-fill request, level-held until i_resp.
REQ-005 i_addr  input  16  instruction-cache line address; bits [3:0] are don't-care.
REQ-006 i_rdata  output  128  line data returned to the instruction cache.
REQ-007 i_resp  output  1  one-cycle completion pulse to the instruction cache.
REQ-008 d_read  input  1  data-cache line-fill request, level-held until d_resp.
REQ-009 d_write  input  1  data-cache write-back request, level-held until d_resp.
REQ-010 d_addr  input  16  data-cache line address.
REQ-011 d_wdata  input  128  write-back line data.
REQ-012 d_rdata  output  128  line data returned to the data cache.
REQ-013 d_resp  output  1  one-cycle completion pulse to the data cache.
REQ-014 pmem_read  output  1  read command to physical memory.
REQ-015 pmem_write  output  1  write command to physical memory.
REQ-016 pmem_address  output  16  line address to physical memory, with [3:0] forced to 0.
REQ-017 pmem_wdata  output  128  write data to physical memory.
REQ-018 pmem_rdata  input  128  read data from physical memory.
REQ-019 pmem_resp  input  1  memory completion pulse.

Function
REQ-020 The FSM SHALL have three states: IDLE, I_BUSY and D_BUSY.
REQ-021 In IDLE, with any request sampled, the arbiter SHALL latch the winner's operation, address and wdata into internal registers and enter the matching BUSY state on the next edge.
REQ-022 pmem_read, pmem_write, pmem_address and pmem_wdata SHALL be driven only from the latched registers, and only while in a BUSY state; in IDLE all of them SHALL be 0.
REQ-023 The first pmem command SHALL appear exactly one cycle after the request is sampled in IDLE.
REQ-024 If d_read and d_write are both high, the request SHALL be treated as a write.
REQ-025 In a BUSY state, pmem_resp SHALL produce a same-cycle resp pulse to the granted requester only, with the FSM returning to IDLE on the next edge.
REQ-026 The non-granted requester's resp SHALL stay 0 throughout.
REQ-027 i_rdata and d_rdata SHALL both equal pmem_rdata combinationally at all times; the resp signals qualify them.
REQ-028 Between back-to-back transactions there SHALL be at least one IDLE cycle (a one-cycle bubble).
REQ-029 A requester that deasserts mid-transaction SHALL NOT abort the transaction; it completes and the resp is still pulsed.
REQ-030 Requests arriving during BUSY SHALL be held off, with no effect until the next IDLE cycle.
REQ-031 A pmem_resp received in IDLE SHALL be ignored.
REQ-032 Priority when both caches request in the same IDLE cycle SHALL follow the Configuration section.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE and all outputs except the rdata buses SHALL be 0 on the next cycle.
REQ-034 On reset, the latched registers SHALL clear to 0 and last_grant SHALL be set to I.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction: no resp is pulsed, and pmem_read/pmem_write are 0 the cycle after reset is sampled.

Configuration
REQ-036 With macro CACHE_ARBITER_RR_EN defined, a last_grant register SHALL update at every grant.
REQ-037 With CACHE_ARBITER_RR_EN defined and both caches requesting together, the side not granted last SHALL win; after reset the data side wins the first tie.
REQ-038 With CACHE_ARBITER_RR_EN undefined, the data side SHALL always win a tie, and last_grant SHALL be absent.

Verification
REQ-039 i_read, i_addr=0x1238 at cycle 0 -> cycle 1: pmem_read=1, pmem_address=0x1230; pmem_resp at cycle 4 -> i_resp=1 in cycle 4 only, IDLE at cycle 5.
REQ-040 d_write, d_addr=0x4000, d_wdata=128'hA5..A5 -> pmem_write=1 with that address and data until pmem_resp; d_resp pulses; i_resp stays 0.
REQ-041 i_read and d_read both high in IDLE, RR undefined -> D then I, always; RR defined -> D, I, D, I across four repeated ties.
REQ-042 d_read starts a D transaction, then i_read rises in its second cycle -> the I transaction starts only after d_resp plus one IDLE cycle.
REQ-043 reset asserted during I_BUSY -> pmem_read=0 next cycle, no i_resp, and a D request is granted first afterwards.
REQ-044 i_read dropped mid-transaction -> pmem_read is held until pmem_resp and i_resp still pulses.
